// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding and default widths.
// Opcode encodings themselves live with the controller, not here.
package inst_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WRAP,
        ST_HALT
    } seq_state_t;

    localparam int SEQ_OP_W = 6;

endpackage

// File: rtl/inst_sequencer_rom_sp.sv
// Single-port DEPTH x OP_W program memory with a registered read, shaped for block-RAM inference.
// A write takes the port for that cycle; the read data register then holds its previous value.
module inst_rom_sp #(
    parameter int DEPTH  = 82,
    parameter int ADDR_W = 7,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [OP_W-1:0]   i_wdata,
    output logic [OP_W-1:0]   o_rdata
);

    logic [OP_W-1:0] r_mem [DEPTH];
    logic [OP_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_sequencer.sv
// Hardware opcode source for the controller: program memory, PC, restart/run bookkeeping and
// the compact/fast mode flop. Halts after MAX_RUNS completed runs (0 = run forever).
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int DEPTH    = 82,
    parameter int ADDR_W   = 7,
    parameter int OP_W     = SEQ_OP_W,
    parameter int MAX_RUNS = 3,
    parameter int RUN_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [OP_W-1:0]   load_data,
    input  logic              start,
    input  logic              next,
    input  logic              prog_end,
    output logic [OP_W-1:0]   opcode,
    output logic              opcode_valid,
    output logic              compact_fast,
    output logic [ADDR_W-1:0] pc,
    output logic [RUN_W-1:0]  run_count,
    output logic              busy,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LD_LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [RUN_W-1:0]  RUN_MAX  = '1;
    localparam logic [RUN_W-1:0]  RUN_LIM  = RUN_W'(MAX_RUNS);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [OP_W-1:0]   r_opcode;
    logic              r_valid;
    logic              r_cf;
    logic [ADDR_W-1:0] r_pc;
    logic [RUN_W-1:0]  r_run;
    logic              r_pend;

    logic              w_in_run;
    logic              w_next_iss;
    logic              w_prog_evt;
    logic              w_wrap_evt;
    logic              w_run_evt;
    logic [RUN_W-1:0]  w_run_inc;
    logic              w_limit;
    logic              w_fetch_go;
    logic              w_load_ok;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_rom_addr;
    logic [OP_W-1:0]   w_rom_rdata;

    assign w_in_run   = (r_state == ST_FETCH) || (r_state == ST_ISSUE);
    assign w_next_iss = (r_state == ST_ISSUE) && next;
    // A pending restart already counted this run, so neither a repeat prog_end nor a wrap counts again.
    assign w_prog_evt = w_in_run && prog_end && !r_pend;
    assign w_wrap_evt = w_next_iss && !r_pend && !prog_end && (r_pc == PC_LAST);
    assign w_run_evt  = w_prog_evt || w_wrap_evt;
    assign w_run_inc  = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
    assign w_limit    = w_run_evt && (MAX_RUNS != 0) && (w_run_inc == RUN_LIM);
    assign w_fetch_go = ((r_state == ST_IDLE) && start) || (w_next_iss && !w_limit);

    // The read is launched on the edge that enters FETCH so the opcode lands one edge later.
    always_comb begin
        w_pc_nxt = r_pc;
        if ((r_state == ST_IDLE) && start) begin
            w_pc_nxt = '0;
        end else if (w_next_iss) begin
            if (r_pend || prog_end || (r_pc == PC_LAST)) begin
                w_pc_nxt = '0;
            end else begin
                w_pc_nxt = r_pc + 1'b1;
            end
        end
    end

    assign w_load_ok  = load_en && ({1'b0, load_addr} < LD_LIMIT) &&
                        (((r_state == ST_IDLE) && !start) || (r_state == ST_HALT));
    assign w_rom_addr = w_load_ok ? load_addr : w_pc_nxt;

    inst_rom_sp #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .OP_W   (OP_W)
    ) u_rom (
        .clk     (clk),
        .i_we    (w_load_ok),
        .i_re    (w_fetch_go),
        .i_addr  (w_rom_addr),
        .i_wdata (load_data),
        .o_rdata (w_rom_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = w_limit ? ST_WRAP : ST_ISSUE;
            ST_ISSUE: begin
                if (w_limit) begin
                    w_state_nxt = ST_WRAP;
                end else if (next) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_WRAP:  w_state_nxt = ST_HALT;
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
            r_valid  <= 1'b0;
            r_cf     <= 1'b0;
            r_pc     <= '0;
            r_run    <= '0;
            r_pend   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_next_iss || (w_state_nxt == ST_WRAP)) begin
                r_valid <= 1'b0;
            end else if (r_state == ST_FETCH) begin
                r_opcode <= w_rom_rdata;
                r_valid  <= 1'b1;
            end
            if (w_run_evt) begin
                r_cf  <= ~r_cf;
                r_run <= w_run_inc;
            end
            if (w_next_iss) begin
                r_pend <= 1'b0;
            end else if (w_prog_evt) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign opcode       = r_opcode;
    assign opcode_valid = r_valid;
    assign compact_fast = r_cf;
    assign pc           = r_pc;
    assign run_count    = r_run;
    assign busy         = (r_state == ST_FETCH) || (r_state == ST_ISSUE) || (r_state == ST_WRAP);
    assign halted       = (r_state == ST_HALT);

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: a default-size instance (MAX_RUNS=3) and a DEPTH=4 instance
// (never halts); expected opcodes are queued when stimulus is driven and checked on opcode_valid.
module tb_inst_sequencer;

    typedef struct {
        logic [7:0] op;
        logic [7:0] pc;
        logic       cf;
        logic [3:0] run;
    } exp_t;

    logic       clk;
    logic       rst;

    logic       load_en, start, next, prog_end;
    logic [6:0] load_addr;
    logic [5:0] load_data;
    logic [5:0] opcode;
    logic       opcode_valid, compact_fast, busy, halted;
    logic [6:0] pc;
    logic [3:0] run_count;

    logic       load_en2, start2, next2, prog_end2;
    logic [1:0] load_addr2;
    logic [5:0] load_data2;
    logic [5:0] opcode2;
    logic       opcode_valid2, compact_fast2, busy2, halted2;
    logic [1:0] pc2;
    logic [3:0] run_count2;

    exp_t q[$];
    int   n_pass = 0;
    int   n_fail = 0;

    inst_sequencer #(
        .DEPTH    (82),
        .ADDR_W   (7),
        .OP_W     (6),
        .MAX_RUNS (3),
        .RUN_W    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .start        (start),
        .next         (next),
        .prog_end     (prog_end),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .compact_fast (compact_fast),
        .pc           (pc),
        .run_count    (run_count),
        .busy         (busy),
        .halted       (halted)
    );

    inst_sequencer #(
        .DEPTH    (4),
        .ADDR_W   (2),
        .OP_W     (6),
        .MAX_RUNS (0),
        .RUN_W    (4)
    ) dut2 (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en2),
        .load_addr    (load_addr2),
        .load_data    (load_data2),
        .start        (start2),
        .next         (next2),
        .prog_end     (prog_end2),
        .opcode       (opcode2),
        .opcode_valid (opcode_valid2),
        .compact_fast (compact_fast2),
        .pc           (pc2),
        .run_count    (run_count2),
        .busy         (busy2),
        .halted       (halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [7:0] p, input logic cf, input logic [3:0] run);
        exp_t e;
        e.op  = op;
        e.pc  = p;
        e.cf  = cf;
        e.run = run;
        q.push_back(e);
    endtask

    // Called at the negedge right after the triggering pulse was sampled.
    task automatic expect_op(input bit d2, input string tag);
        exp_t e;
        int   lat;
        e = q.pop_front();
        chk({tag, ".vlow"}, 32'(d2 ? opcode_valid2 : opcode_valid), 32'd0);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (d2 ? opcode_valid2 : opcode_valid) begin
                lat = i;
                break;
            end
        end
        chk({tag, ".lat"}, 32'(lat), 32'd1);
        if (lat != 0) begin
            chk({tag, ".op"},  32'(d2 ? opcode2 : opcode), 32'(e.op));
            chk({tag, ".pc"},  d2 ? 32'(pc2) : 32'(pc), 32'(e.pc));
            chk({tag, ".cf"},  32'(d2 ? compact_fast2 : compact_fast), 32'(e.cf));
            chk({tag, ".run"}, 32'(d2 ? run_count2 : run_count), 32'(e.run));
        end
    endtask

    task automatic drive1(input logic s, input logic n, input logic p);
        start = s; next = n; prog_end = p;
        @(negedge clk);
        start = 1'b0; next = 1'b0; prog_end = 1'b0;
    endtask

    task automatic drive2(input logic s, input logic n, input logic p);
        start2 = s; next2 = n; prog_end2 = p;
        @(negedge clk);
        start2 = 1'b0; next2 = 1'b0; prog_end2 = 1'b0;
    endtask

    task automatic load1(input logic [6:0] a, input logic [5:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic load2(input logic [1:0] a, input logic [5:0] d);
        load_en2 = 1'b1; load_addr2 = a; load_data2 = d;
        @(negedge clk);
        load_en2 = 1'b0;
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, ".op"},     32'(opcode), 32'd0);
        chk({tag, ".valid"},  32'(opcode_valid), 32'd0);
        chk({tag, ".cf"},     32'(compact_fast), 32'd0);
        chk({tag, ".pc"},     32'(pc), 32'd0);
        chk({tag, ".run"},    32'(run_count), 32'd0);
        chk({tag, ".busy"},   32'(busy), 32'd0);
        chk({tag, ".halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; next = 1'b0; prog_end = 1'b0;
        load_en2 = 1'b0; load_addr2 = '0; load_data2 = '0;
        start2 = 1'b0; next2 = 1'b0; prog_end2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero1("reset");
        chk("reset2.busy", 32'(busy2), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        load1(7'd0, 6'h01);
        load1(7'd1, 6'h02);
        load1(7'd2, 6'h03);

        push(8'h01, 8'd0, 1'b0, 4'd0);
        drive1(1'b1, 1'b0, 1'b0);
        expect_op(1'b0, "start");
        chk("start.busy", 32'(busy), 32'd1);
        push(8'h02, 8'd1, 1'b0, 4'd0);
        drive1(1'b0, 1'b1, 1'b0);
        expect_op(1'b0, "next1");
        push(8'h03, 8'd2, 1'b0, 4'd0);
        drive1(1'b0, 1'b1, 1'b0);
        expect_op(1'b0, "next2");

        drive1(1'b0, 1'b0, 1'b1);
        chk("pend1.cf", 32'(compact_fast), 32'd1);
        chk("pend1.run", 32'(run_count), 32'd1);
        chk("pend1.hold", 32'(opcode_valid), 32'd1);
        push(8'h01, 8'd0, 1'b1, 4'd1);
        drive1(1'b0, 1'b1, 1'b0);
        expect_op(1'b0, "restart1");

        drive1(1'b0, 1'b0, 1'b1);
        drive1(1'b0, 1'b0, 1'b1);
        chk("repeat.cf", 32'(compact_fast), 32'd0);
        chk("repeat.run", 32'(run_count), 32'd2);
        push(8'h01, 8'd0, 1'b0, 4'd2);
        drive1(1'b0, 1'b1, 1'b0);
        expect_op(1'b0, "restart2");

        drive1(1'b0, 1'b1, 1'b1);
        chk("wrap.busy", 32'(busy), 32'd1);
        chk("wrap.halted", 32'(halted), 32'd0);
        chk("wrap.valid", 32'(opcode_valid), 32'd0);
        @(negedge clk);
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.busy", 32'(busy), 32'd0);
        drive1(1'b0, 1'b1, 1'b0);
        drive1(1'b1, 1'b0, 1'b0);
        drive1(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("halt.halted2", 32'(halted), 32'd1);
        chk("halt.valid", 32'(opcode_valid), 32'd0);
        chk("halt.cf", 32'(compact_fast), 32'd1);
        chk("halt.run", 32'(run_count), 32'd3);
        chk("halt.pc", 32'(pc), 32'd0);
        chk("halt.op", 32'(opcode), 32'h01);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(8'h01, 8'd0, 1'b0, 4'd0);
        drive1(1'b1, 1'b0, 1'b0);
        expect_op(1'b0, "rerun");
        load1(7'd0, 6'h2A);
        push(8'h02, 8'd1, 1'b0, 4'd0);
        drive1(1'b0, 1'b1, 1'b0);
        expect_op(1'b0, "rerun.next");
        #2 rst = 1'b1;
        #1 chk_zero1("async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(8'h01, 8'd0, 1'b0, 4'd0);
        drive1(1'b1, 1'b0, 1'b0);
        expect_op(1'b0, "retained");

        load2(2'd0, 6'h11);
        load2(2'd1, 6'h12);
        load2(2'd2, 6'h13);
        load2(2'd3, 6'h14);
        push(8'h11, 8'd0, 1'b0, 4'd0);
        drive2(1'b1, 1'b0, 1'b0);
        expect_op(1'b1, "d4.start");
        push(8'h12, 8'd1, 1'b0, 4'd0);
        drive2(1'b0, 1'b1, 1'b0);
        expect_op(1'b1, "d4.n1");
        push(8'h13, 8'd2, 1'b0, 4'd0);
        drive2(1'b0, 1'b1, 1'b0);
        expect_op(1'b1, "d4.n2");
        push(8'h14, 8'd3, 1'b0, 4'd0);
        drive2(1'b0, 1'b1, 1'b0);
        expect_op(1'b1, "d4.n3");
        push(8'h11, 8'd0, 1'b1, 4'd1);
        drive2(1'b0, 1'b1, 1'b0);
        expect_op(1'b1, "d4.wrap");
        push(8'h12, 8'd1, 1'b1, 4'd1);
        drive2(1'b0, 1'b1, 1'b0);
        expect_op(1'b1, "d4.n4");
        push(8'h11, 8'd0, 1'b0, 4'd2);
        drive2(1'b0, 1'b1, 1'b1);
        expect_op(1'b1, "d4.same");
        chk("d4.halted", 32'(halted2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
